// File: rtl/instr_mem_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_pipelined
// Description : Byte-array instruction memory for the fetch path. It returns a
//               little-endian 32-bit fetch after a programmable latency, with
//               valid/ready on request and response, a byte-wide program-load
//               port and a flush for branch redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_pipelined #(
  parameter int          ADDR_W      = 64,
  parameter int          DEPTH_BYTES = 16,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013,
  localparam int         IDX_W       = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_inst,
  output logic [1:0]        rsp_fault,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [7:0]        prog_wdata
);

  localparam int LAST = LATENCY - 1;

  // Storage is deliberately not reset so loaded code survives a core reset.
  logic [7:0] mem_q [DEPTH_BYTES];

  logic              w_advance;
  logic              w_accept;
  logic [IDX_W-1:0]  w_idx0;
  logic [IDX_W-1:0]  w_idx1;
  logic [IDX_W-1:0]  w_idx2;
  logic [IDX_W-1:0]  w_idx3;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic [1:0]        w_fault;
  logic [31:0]       w_inst;

  // Stage LAST is the output stage; stage 0 receives newly accepted fetches.
  logic [LATENCY-1:0]       vld_q,   vld_d;
  logic [LATENCY-1:0][31:0] inst_q,  inst_d;
  logic [LATENCY-1:0][1:0]  fault_q, fault_d;

  // The whole pipe moves as one; a held output stalls every stage behind it.
  assign w_advance = ~vld_q[LAST] | rsp_ready;
  // A load cycle blocks fetches so a fetch never samples a byte being written.
  assign req_ready = w_advance & ~prog_we;
  assign w_accept  = req_valid & req_ready;

  // Byte lanes wrap modulo the storage size (only reachable on faulted fetches).
  assign w_idx0 = req_addr[IDX_W-1:0];
  assign w_idx1 = w_idx0 + IDX_W'(1);
  assign w_idx2 = w_idx0 + IDX_W'(2);
  assign w_idx3 = w_idx0 + IDX_W'(3);

  assign w_misaligned   = (req_addr[1:0] != 2'b00);
  assign w_out_of_range = |req_addr[ADDR_W-1:IDX_W];

  // Program-load write port: one byte per cycle.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_wdata;
    end
  end

  // Fetch word and fault code; out-of-range takes priority over misalignment.
  always_comb begin
    w_fault = 2'b00;
    if (w_out_of_range) begin
      w_fault = 2'b10;
    end else if (w_misaligned) begin
      w_fault = 2'b01;
    end
    w_inst = {mem_q[w_idx3], mem_q[w_idx2], mem_q[w_idx1], mem_q[w_idx0]};
    if (w_fault != 2'b00) begin
      w_inst = NOP_INST;
    end
  end

  // Next state of the response shift register, including flush of valid bits.
  always_comb begin
    vld_d   = vld_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    if (w_advance) begin
      vld_d[0]   = w_accept;
      inst_d[0]  = w_inst;
      fault_d[0] = w_fault;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i]   = vld_q[i-1];
        inst_d[i]  = inst_q[i-1];
        fault_d[i] = fault_q[i-1];
      end
    end
    // A fetch accepted alongside a flush belongs to the redirected stream.
    if (flush) begin
      vld_d    = '0;
      vld_d[0] = w_accept;
    end
  end

  // Pipeline registers; reset drops every in-flight fetch immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= '0;
      inst_q  <= '0;
      fault_q <= '0;
    end else begin
      vld_q   <= vld_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
    end
  end

  assign rsp_valid = vld_q[LAST];
  assign rsp_inst  = inst_q[LAST];
  assign rsp_fault = fault_q[LAST];

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_pipelined.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_mem_pipelined
// Description : Directed bench for instr_mem_pipelined. Three instances with
//               LATENCY 1, 2 and 3 share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_mem_pipelined;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic [63:0]      req_addr;
  logic             rsp_ready;
  logic             flush;
  logic             prog_we;
  logic [3:0]       prog_addr;
  logic [7:0]       prog_wdata;

  logic [2:0]       rr;
  logic [2:0]       rv;
  logic [2:0][31:0] ri;
  logic [2:0][1:0]  rf;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img   [16];
  logic [31:0] exp_w [4];

  always #5 clk = ~clk;

  // Index k holds the instance with LATENCY k+1.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    instr_mem_pipelined #(
      .ADDR_W      (64),
      .DEPTH_BYTES (16),
      .LATENCY     (g + 1),
      .NOP_INST    (NOP)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (rr[g]),
      .req_addr   (req_addr),
      .rsp_valid  (rv[g]),
      .rsp_ready  (rsp_ready),
      .rsp_inst   (ri[g]),
      .rsp_fault  (rf[g]),
      .flush      (flush),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_wdata (prog_wdata)
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog_byte(input logic [3:0] a, input logic [7:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    tick();
    prog_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    img = '{8'h83, 8'h34, 8'h85, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11,
            8'h88, 8'h77, 8'h66, 8'h55, 8'hCC, 8'hBB, 8'hAA, 8'h99};
    exp_w = '{32'h0285_3483, 32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;

    // Reset state
    #12;
    check("reset_valid", 64'(rv), 64'(3'b000));
    for (int k = 0; k < 3; k++) begin
      check("reset_inst", 64'(ri[k]), 64'd0);
      check("reset_fault", 64'(rf[k]), 64'd0);
    end
    tick();
    rst_n = 1'b1;

    // Load with a fetch pending: load blocks the request
    req_valid = 1'b1; req_addr = 64'd0;
    prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = img[0];
    #1;
    check("ready_during_prog", 64'(rr), 64'(3'b000));
    tick();
    prog_we = 1'b0; req_valid = 1'b0;
    check("no_rsp_after_blocked_req", 64'(rv), 64'(3'b000));
    for (int k = 1; k < 16; k++) prog_byte(4'(k), img[k]);
    #1;
    check("ready_idle", 64'(rr), 64'(3'b111));

    // Test 1: LATENCY=1 fetch of address 0
    req_valid = 1'b1; req_addr = 64'd0;
    tick();
    req_valid = 1'b0;
    check("l1_valid", 64'(rv[0]), 64'd1);
    check("l1_inst", 64'(ri[0]), 64'h0285_3483);
    check("l1_fault", 64'(rf[0]), 64'd0);
    tick();
    check("l1_valid_after", 64'(rv[0]), 64'd0);
    repeat (4) tick();

    // Test 2: LATENCY=3 back-to-back 0,4,8,12
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 4);
      req_addr  = 64'(4 * c);
      tick();
      check("l3_stream_valid", 64'(rv[2]), 64'((c >= 2) && (c <= 5)));
      if ((c >= 2) && (c <= 5)) begin
        check("l3_stream_inst", 64'(ri[2]), 64'(exp_w[c-2]));
      end
    end
    repeat (2) tick();

    // Test 3: faults on LATENCY=1
    req_valid = 1'b1; req_addr = 64'd2;
    tick();
    check("mis_valid", 64'(rv[0]), 64'd1);
    check("mis_inst", 64'(ri[0]), 64'(NOP));
    check("mis_fault", 64'(rf[0]), 64'd1);
    req_addr = 64'd16;
    tick();
    check("oor16_inst", 64'(ri[0]), 64'(NOP));
    check("oor16_fault", 64'(rf[0]), 64'd2);
    req_addr = 64'd18;
    tick();
    check("oor18_inst", 64'(ri[0]), 64'(NOP));
    check("oor18_fault", 64'(rf[0]), 64'd2);
    req_addr = 64'd12;
    tick();
    check("ok12_inst", 64'(ri[0]), 64'h99AA_BBCC);
    check("ok12_fault", 64'(rf[0]), 64'd0);
    req_valid = 1'b0;
    repeat (4) tick();

    // Test 4: stall with two fetches in flight on LATENCY=2
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 64'd0;
    tick();
    check("stall_first_valid", 64'(rv[1]), 64'd0);
    req_addr = 64'd4;
    #1;
    check("stall_ready_before_full", 64'(rr[1]), 64'd1);
    tick();
    check("stall_head_valid", 64'(rv[1]), 64'd1);
    check("stall_head_inst", 64'(ri[1]), 64'(exp_w[0]));
    req_addr = 64'd8;
    #1;
    check("stall_ready_full", 64'(rr[1]), 64'd0);
    tick();
    check("stall_hold_valid", 64'(rv[1]), 64'd1);
    check("stall_hold_inst", 64'(ri[1]), 64'(exp_w[0]));
    tick();
    check("stall_hold_inst2", 64'(ri[1]), 64'(exp_w[0]));
    rsp_ready = 1'b1; req_valid = 1'b0;
    tick();
    check("stall_second_valid", 64'(rv[1]), 64'd1);
    check("stall_second_inst", 64'(ri[1]), 64'(exp_w[1]));
    tick();
    check("stall_no_dup", 64'(rv[1]), 64'd0);
    repeat (6) tick();

    // Test 5: flush with a same-cycle request on LATENCY=2
    req_valid = 1'b1; req_addr = 64'd0;
    tick();
    req_addr = 64'd4;
    tick();
    req_addr = 64'd8; flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_cleared", 64'(rv[1]), 64'd0);
    tick();
    check("flush_kept_valid", 64'(rv[1]), 64'd1);
    check("flush_kept_inst", 64'(ri[1]), 64'(exp_w[2]));
    tick();
    check("flush_only_one", 64'(rv[1]), 64'd0);
    repeat (4) tick();

    // Test 6: async reset mid-stream, storage survives
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      req_addr = 64'(4 * c);
      tick();
    end
    req_valid = 1'b0;
    check("pre_reset_valid", 64'(rv[2]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(rv), 64'(3'b000));
    check("async_reset_inst", 64'(ri[2]), 64'd0);
    rst_n = 1'b1;
    tick();
    req_valid = 1'b1; req_addr = 64'd12;
    tick();
    check("post_reset_inst12", 64'(ri[0]), 64'h99AA_BBCC);
    req_addr = 64'd0;
    tick();
    req_valid = 1'b0;
    check("post_reset_inst0", 64'(ri[0]), 64'h0285_3483);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
